// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard. The sequence is: inhibit the clock,
// request-to-send, shift bits out on the device clock, then check the device ack.
// The clock and data pads are open-drain. The *_oe outputs are active-high
// pull-low enables. The pads themselves are tri-stated at the top level.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 6000,
    parameter int SETUP_CYC   = 250,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    // Odd parity bit: set when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t      state_r;
    logic [1:0]  clk_sync_r;
    logic [1:0]  data_sync_r;
    logic        clk_prev_r;
    logic [7:0]  byte_r;
    logic        parity_r;
    logic [3:0]  bit_idx_r;
    logic [19:0] cnt_r;
    logic        ack_ok_r;

    logic        clk_s;
    logic        data_s;
    logic        fall_s;
    logic        lines_idle_s;
    logic        timeout_s;

    assign clk_s        = clk_sync_r[1];
    assign data_s       = data_sync_r[1];
    assign fall_s       = clk_prev_r & ~clk_s;
    assign lines_idle_s = clk_s & data_s;
    assign timeout_s    = (cnt_r == 20'(TIMEOUT_CYC - 1));

    // Two-flop synchronisers for the asynchronous pad inputs, plus a delayed copy of the clock for edge detection.
    // These reset to 1, which is the idle line level, so that leaving reset does not produce a false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk_in};
            data_sync_r <= {data_sync_r[0], ps2_data_in};
            clk_prev_r  <= clk_s;
        end
    end

    // Frame sequencer with registered line enables and handshake outputs.
    // Outputs default to their idle values at the top of each cycle, which makes the done/err signals one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            byte_r      <= 8'h00;
            parity_r    <= 1'b0;
            bit_idx_r   <= 4'd0;
            cnt_r       <= 20'd0;
            ack_ok_r    <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (tx_valid) begin
                        byte_r      <= tx_data;
                        parity_r    <= odd_parity(tx_data);
                        cnt_r       <= 20'd0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= S_INHIBIT;
                    end else begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_r == 20'(INHIBIT_CYC - 1)) begin
                        cnt_r       <= 20'd0;
                        ps2_data_oe <= 1'b1;
                        state_r     <= S_REQ;
                    end else begin
                        cnt_r <= cnt_r + 20'd1;
                    end
                end
                S_REQ: begin
                    if (cnt_r == 20'(SETUP_CYC - 1)) begin
                        // Release the clock and leave the start bit (data low) driven. The device clocks from here on.
                        cnt_r      <= 20'd0;
                        bit_idx_r  <= 4'd0;
                        ps2_clk_oe <= 1'b0;
                        state_r    <= S_SHIFT;
                    end else begin
                        cnt_r <= cnt_r + 20'd1;
                    end
                end
                S_SHIFT: begin
                    if (fall_s) begin
                        cnt_r     <= 20'd0;
                        bit_idx_r <= bit_idx_r + 4'd1;
                        if (bit_idx_r <= 4'd7) begin
                            ps2_data_oe <= ~byte_r[bit_idx_r[2:0]];
                        end else if (bit_idx_r == 4'd8) begin
                            ps2_data_oe <= ~parity_r;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state_r     <= S_ACK;
                        end
                    end else if (timeout_s) begin
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 20'd1;
                    end
                end
                S_ACK: begin
                    if (fall_s) begin
                        cnt_r    <= 20'd0;
                        ack_ok_r <= ~data_s;
                        state_r  <= S_WAIT_IDLE;
                    end else if (timeout_s) begin
                        tx_err   <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 20'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (lines_idle_s) begin
                        tx_done  <= ack_ok_r;
                        tx_err   <= ~ack_ok_r;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= S_IDLE;
                    end else if (fall_s) begin
                        cnt_r <= 20'd0;
                    end else if (timeout_s) begin
                        tx_err   <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 20'd1;
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx. An open-drain line model and a keyboard model drive the device side.
module tb_ps2_host_tx;

    localparam int INH = 60;
    localparam int SET = 10;
    localparam int TMO = 400;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic       dev_clk_low;
    logic       dev_data_low;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    // Open-drain wired-AND: a line is low if either side pulls it low.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .SETUP_CYC(SET), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    // Count result pulses, and count any cycle in which done and err are both asserted.
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    // Stop the run if the bench itself gets stuck.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
    endtask

    // Count the inhibit and request-to-send phases, starting from the current sample, until the clock is released.
    task automatic measure_preamble(output int n_inh, output int n_req);
        n_inh = 0;
        n_req = 0;
        for (int i = 0; i < 2000; i++) begin
            if (ps2_clk_oe && !ps2_data_oe) n_inh++;
            else if (ps2_clk_oe && ps2_data_oe) n_req++;
            else if (n_inh + n_req > 0) break;
            @(negedge clk);
        end
        check_eq("clk_released", 32'(ps2_clk_oe), 32'd0);
    endtask

    // Keyboard model. It clocks nfalls falling edges and samples data during each high phase.
    // On the 11th fall it drives the ack if requested. If hold > 0, it keeps both lines low for hold extra cycles.
    task automatic dev_frame(input int nfalls, input bit ack, input int hold, output logic [9:0] bits);
        int d0;
        bits = 10'd0;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11) dev_data_low = ack;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (k == 11 && hold > 0) begin
                d0 = done_cnt;
                repeat (hold) @(negedge clk);
                check_eq("glitch_busy", 32'(busy), 32'd1);
                check_eq("glitch_no_done", 32'(done_cnt - d0), 32'd0);
            end
            dev_clk_low = 1'b0;
            if (k == 11) dev_data_low = 1'b0;
            repeat (H / 2) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_data_in;
            repeat (H / 2) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check_eq("idle_reached", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] bits;
        int ni, nr, d0, e0, c;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check_eq("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check_eq("rst_done_err", 32'({tx_done, tx_err}), 32'd0);

        // 1: 0xED with ack
        send(8'hED);
        tx_valid = 1'b0;
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_ready", 32'(tx_ready), 32'd0);
        measure_preamble(ni, nr);
        check_eq("t1_inhibit_cyc", 32'(ni), 32'(INH));
        check_eq("t1_setup_cyc", 32'(nr), 32'(SET));
        d0 = done_cnt; e0 = err_cnt;
        dev_frame(11, 1'b1, 0, bits);
        wait_idle();
        check_eq("t1_data", 32'(bits[7:0]), 32'hED);
        check_eq("t1_parity", 32'(bits[8]), 32'd1);
        check_eq("t1_stop", 32'(bits[9]), 32'd1);
        check_eq("t1_done", 32'(done_cnt - d0), 32'd1);
        check_eq("t1_err", 32'(err_cnt - e0), 32'd0);
        check_eq("t1_done_pulse", 32'(tx_done), 32'd0);

        // 2: 0x01 with nack
        send(8'h01);
        tx_valid = 1'b0;
        measure_preamble(ni, nr);
        d0 = done_cnt; e0 = err_cnt;
        dev_frame(11, 1'b0, 0, bits);
        wait_idle();
        check_eq("t2_data", 32'(bits[7:0]), 32'h01);
        check_eq("t2_parity", 32'(bits[8]), 32'd0);
        check_eq("t2_err", 32'(err_cnt - e0), 32'd1);
        check_eq("t2_done", 32'(done_cnt - d0), 32'd0);

        // 3: 0xFF with no device clock, so the transfer times out
        send(8'hFF);
        tx_valid = 1'b0;
        measure_preamble(ni, nr);
        d0 = done_cnt;
        c = 0;
        for (int i = 0; i < TMO + 50; i++) begin
            @(negedge clk);
            c++;
            if (tx_err) break;
        end
        check_eq("t3_timeout_cyc", 32'(c), 32'(TMO));
        check_eq("t3_err", 32'(tx_err), 32'd1);
        check_eq("t3_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        @(negedge clk);
        check_eq("t3_ready_next", 32'(tx_ready), 32'd1);
        check_eq("t3_err_pulse", 32'(tx_err), 32'd0);
        check_eq("t3_no_done", 32'(done_cnt - d0), 32'd0);

        // 4: tx_valid held high; the data changes to 0x55 while the 0xAA frame is busy
        send(8'hAA);
        tx_data = 8'h55;
        measure_preamble(ni, nr);
        dev_frame(11, 1'b1, 0, bits);
        check_eq("t4_first", 32'(bits[7:0]), 32'hAA);
        wait_idle();
        tx_valid = 1'b0;
        check_eq("t4_second_busy", 32'(busy), 32'd1);
        measure_preamble(ni, nr);
        dev_frame(11, 1'b1, 0, bits);
        wait_idle();
        check_eq("t4_second", 32'(bits[7:0]), 32'h55);

        // 5: asynchronous reset asserted during SHIFT bit 4
        send(8'h3C);
        tx_valid = 1'b0;
        measure_preamble(ni, nr);
        dev_frame(5, 1'b1, 0, bits);
        check_eq("t5_data_oe_bit4", 32'(ps2_data_oe), 32'(~bits[4] & 1'b1));
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_ready", 32'(tx_ready), 32'd1);
        check_eq("t5_busy", 32'(busy), 32'd0);

        // 6: device keeps both lines low after the ack
        send(8'hF0);
        tx_valid = 1'b0;
        measure_preamble(ni, nr);
        d0 = done_cnt;
        dev_frame(11, 1'b1, 100, bits);
        wait_idle();
        check_eq("t6_done", 32'(done_cnt - d0), 32'd1);
        check_eq("t6_data", 32'(bits[7:0]), 32'hF0);

        check_eq("never_both", 32'(both_cnt), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
